// File: rtl/data_snapshot_pkg.sv
// data_snapshot_pkg: FSM states and aux-buffer map shared by the snapshot engine.
package data_snapshot_pkg;
  typedef enum logic [2:0] {IDLE, CFG, CPU, MEM, DONE} state_t;
  localparam int CTRL_ADDR = 0;
  localparam int BASE_ADDR0 = 2;
endpackage

// File: rtl/snapshot_addr_gen.sv
// snapshot_addr_gen: per-channel read address counter, loaded with the window base and wrapping at 2^ADDR_WIDTH.
module snapshot_addr_gen #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr <= '0;
    else if (load) addr <= base;
    else if (step) addr <= addr + ADDR_WIDTH'(1);
endmodule

// File: rtl/data_snapshot_engine.sv
// data_snapshot_engine: on each v_sync fall copies CPU registers and memory windows into the aux buffer.
// Define DSE_CHECKSUM_EN to append an XOR checksum of the frame at SNAP_BASE-1.
module data_snapshot_engine
  import data_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEMORY_ADDRESS_WIDTH = 11,
  parameter int AUX_ADDRESS_WIDTH = 5,
  parameter int CPU_CONTENT_ELEMENTS = 10,
  parameter int MEM_CHANNELS = 2,
  parameter int WINDOW_DEPTH = 4,
  parameter int SNAP_BASE = 8
) (
  input  logic                                       clock_in,
  input  logic                                       reset_n_in,
  input  logic                                       v_sync_in,
  input  logic [DATA_WIDTH-1:0]                      cpu_content_in,
  input  logic [MEM_CHANNELS*DATA_WIDTH-1:0]         mem_data_in,
  output logic [MEM_CHANNELS*MEMORY_ADDRESS_WIDTH-1:0] mem_address_out,
  output logic [MEM_CHANNELS-1:0]                    mem_read_out,
  input  logic [DATA_WIDTH-1:0]                      aux_data_in,
  output logic [AUX_ADDRESS_WIDTH-1:0]               aux_raddress_out,
  output logic                                       aux_wr_out,
  output logic [AUX_ADDRESS_WIDTH-1:0]               aux_waddress_out,
  output logic [DATA_WIDTH-1:0]                      aux_data_out,
  output logic [CPU_CONTENT_ELEMENTS-1:0]            content_enable_out,
  output logic                                       busy_out,
  output logic                                       frame_done_out,
  output logic                                       overrun_out
);
  localparam int MAW = MEMORY_ADDRESS_WIDTH;
  localparam int AW = AUX_ADDRESS_WIDTH;
  localparam int CW = $clog2(CPU_CONTENT_ELEMENTS + WINDOW_DEPTH + MEM_CHANNELS + 2);
  localparam int KW = $clog2(MEM_CHANNELS + 1);

  if (SNAP_BASE + CPU_CONTENT_ELEMENTS + MEM_CHANNELS * WINDOW_DEPTH > 2 ** AUX_ADDRESS_WIDTH ||
      2 + MEM_CHANNELS > SNAP_BASE) begin : g_bad_map
    $error("data_snapshot_engine: aux map does not fit the configuration");
  end

  state_t state, state_nx;
  logic v_q, v_qq, start, mem_wr, unused_aux;
  logic [MEM_CHANNELS:0] ctrl;
  logic [CW-1:0] cnt, cnt_nx;
  logic [KW-1:0] ch, ch_nx, first_ch, next_ch;
  logic [MEM_CHANNELS-1:0] load, rd;
  logic [MAW-1:0] addr [MEM_CHANNELS];

  // Lowest enabled channel at or above 'from'; MEM_CHANNELS means none left.
  function automatic logic [KW-1:0] find_ch(input logic [MEM_CHANNELS-1:0] en, input int from);
    find_ch = KW'(MEM_CHANNELS);
    for (int i = MEM_CHANNELS - 1; i >= 0; i--) if (en[i] && i >= from) find_ch = KW'(i);
  endfunction

  assign start = v_qq && !v_q;
  assign first_ch = find_ch(ctrl[MEM_CHANNELS:1], 0);
  assign next_ch = find_ch(ctrl[MEM_CHANNELS:1], int'(ch) + 1);
  assign unused_aux = &{1'b0, aux_data_in};

  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) begin
      state <= IDLE;
      v_q <= 1'b1;
      v_qq <= 1'b1;
      ctrl <= '0;
      cnt <= '0;
      ch <= '0;
    end else begin
      state <= state_nx;
      v_q <= v_sync_in;
      v_qq <= v_q;
      cnt <= cnt_nx;
      ch <= ch_nx;
      if (state == CFG && cnt == '0) ctrl <= aux_data_in[MEM_CHANNELS:0];
    end

  always_comb begin
    state_nx = state;
    cnt_nx = cnt + CW'(1);
    ch_nx = ch;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = CFG;
      end
      CFG: if (cnt == CW'(MEM_CHANNELS)) begin
        cnt_nx = '0;
        ch_nx = first_ch;
        state_nx = ctrl[0] ? CPU : first_ch != KW'(MEM_CHANNELS) ? MEM : DONE;
      end
      CPU: if (cnt == CW'(CPU_CONTENT_ELEMENTS - 1)) begin
        cnt_nx = '0;
        state_nx = ch != KW'(MEM_CHANNELS) ? MEM : DONE;
      end
      MEM: if (cnt == CW'(WINDOW_DEPTH)) begin
        cnt_nx = '0;
        ch_nx = next_ch;
        if (next_ch == KW'(MEM_CHANNELS)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar k = 0; k < MEM_CHANNELS; k++) begin : g_ch
    assign rd[k] = state == MEM && ch == KW'(k) && cnt < CW'(WINDOW_DEPTH);
    assign load[k] = state == CFG && cnt == CW'(k + 1);
    snapshot_addr_gen #(.ADDR_WIDTH(MAW)) u_addr (
      .clk(clock_in),
      .rst_n(reset_n_in),
      .load(load[k]),
      .step(rd[k]),
      .base(aux_data_in[MAW-1:0]),
      .addr(addr[k])
    );
    assign mem_address_out[k*MAW +: MAW] = rd[k] ? addr[k] : '0;
  end

  assign mem_read_out = rd;
  assign mem_wr = state == MEM && cnt != '0;
  assign busy_out = state != IDLE;
  assign frame_done_out = state == DONE;
  assign overrun_out = start && state != IDLE;
  assign content_enable_out = state == CPU ? CPU_CONTENT_ELEMENTS'(1) << cnt : '0;
  assign aux_raddress_out = state != CFG ? '0 :
                            cnt == '0 ? AW'(CTRL_ADDR) : AW'(BASE_ADDR0 - 1 + int'(cnt));

`ifdef DSE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) csum <= '0;
    else csum <= state == IDLE ? '0 : aux_wr_out ? csum ^ aux_data_out : csum;
`endif

  always_comb begin
    aux_wr_out = state == CPU || mem_wr;
    aux_waddress_out = '0;
    aux_data_out = '0;
    if (state == CPU) begin
      aux_waddress_out = AW'(SNAP_BASE + int'(cnt));
      aux_data_out = cpu_content_in;
    end else if (mem_wr) begin
      aux_waddress_out = AW'(SNAP_BASE + CPU_CONTENT_ELEMENTS + int'(ch) * WINDOW_DEPTH + int'(cnt) - 1);
      aux_data_out = mem_data_in[int'(ch)*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef DSE_CHECKSUM_EN
    else if (state == DONE) begin
      aux_wr_out = 1'b1;
      aux_waddress_out = AW'(SNAP_BASE - 1);
      aux_data_out = csum;
    end
`endif
  end
endmodule

// File: tb/tb_data_snapshot_engine.sv
// tb_data_snapshot_engine: random frames checked against a list-based model of the aux writes, reads and timing.
module tb_data_snapshot_engine;
  localparam int DW = 16, MAW = 11, AW = 5, CE = 10, MC = 2, WD = 4, SB = 8;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  logic clk = 0, rst_n = 0, v_sync = 1;
  logic [DW-1:0] cpu_content, aux_rdata, aux_wdata;
  logic [MC*DW-1:0] mem_rdata = '0, pend = '0;
  logic [MC*MAW-1:0] mem_addr;
  logic [MC-1:0] mem_rd;
  logic [AW-1:0] aux_ra, aux_wa;
  logic aux_wr, busy, done, ovr;
  logic [CE-1:0] ce;

  logic [DW-1:0] aux_mem [32];
  logic [DW-1:0] mem0 [2048];
  logic [DW-1:0] mem1 [2048];
  logic [DW-1:0] cpu_regs [CE];
  wr_t wq[$], eq[$];
  logic [MAW-1:0] rq0[$], rq1[$];
  logic [CE-1:0] ceq[$];
  int checks = 0, failures = 0, cyc = 0;
  int busy_cyc = -1, done_cyc = -1, done_cnt = 0, ovr_cnt = 0;

  always #5 clk = ~clk;

  data_snapshot_engine dut (
    .clock_in(clk), .reset_n_in(rst_n), .v_sync_in(v_sync), .cpu_content_in(cpu_content),
    .mem_data_in(mem_rdata), .mem_address_out(mem_addr), .mem_read_out(mem_rd),
    .aux_data_in(aux_rdata), .aux_raddress_out(aux_ra), .aux_wr_out(aux_wr),
    .aux_waddress_out(aux_wa), .aux_data_out(aux_wdata), .content_enable_out(ce),
    .busy_out(busy), .frame_done_out(done), .overrun_out(ovr)
  );

  assign aux_rdata = aux_mem[aux_ra];

  always_comb begin
    cpu_content = '0;
    for (int i = 0; i < CE; i++) if (ce[i]) cpu_content = cpu_regs[i];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= pend;
  end

  // Memory answers one cycle after the strobe; random junk when not read.
  always @(negedge clk) begin
    pend[0 +: DW] = mem_rd[0] ? mem0[mem_addr[0 +: MAW]] : DW'($urandom);
    pend[DW +: DW] = mem_rd[1] ? mem1[mem_addr[MAW +: MAW]] : DW'($urandom);
    if (mem_rd[0]) rq0.push_back(mem_addr[0 +: MAW]);
    if (mem_rd[1]) rq1.push_back(mem_addr[MAW +: MAW]);
    if (aux_wr) begin
      wq.push_back('{aux_wa, aux_wdata});
      aux_mem[aux_wa] = aux_wdata;
    end
    if (ce != '0) ceq.push_back(ce);
    if (busy && busy_cyc < 0) busy_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ovr) ovr_cnt++;
  end

  task automatic run_frame(input logic [15:0] ctrl, input logic [MAW-1:0] b0, input logic [MAW-1:0] b1,
                           input int ovr_at, input string tag);
    logic [MAW-1:0] e0[$], e1[$];
    logic [CE-1:0] one = 1;
    logic [DW-1:0] x;
    int nch, lat, n;
    aux_mem[0] = ctrl;
    aux_mem[2] = {5'($urandom), b0};
    aux_mem[3] = {5'($urandom), b1};
    for (int i = 0; i < CE; i++) cpu_regs[i] = DW'($urandom);
    wq.delete(); eq.delete(); rq0.delete(); rq1.delete(); ceq.delete();
    busy_cyc = -1; done_cyc = -1; done_cnt = 0; ovr_cnt = 0; nch = 0;
    if (ctrl[0]) for (int i = 0; i < CE; i++) eq.push_back('{AW'(SB + i), cpu_regs[i]});
    if (ctrl[1]) begin
      nch++;
      for (int j = 0; j < WD; j++) begin
        e0.push_back(MAW'(b0 + j));
        eq.push_back('{AW'(SB + CE + j), mem0[MAW'(b0 + j)]});
      end
    end
    if (ctrl[2]) begin
      nch++;
      for (int j = 0; j < WD; j++) begin
        e1.push_back(MAW'(b1 + j));
        eq.push_back('{AW'(SB + CE + WD + j), mem1[MAW'(b1 + j)]});
      end
    end
`ifdef DSE_CHECKSUM_EN
    x = '0;
    foreach (eq[i]) x ^= eq[i].d;
    eq.push_back('{AW'(SB - 1), x});
`else
    x = '0;
`endif
    lat = MC + 1 + (ctrl[0] ? CE : 0) + nch * (WD + 1);
    @(posedge clk); #2 v_sync = 0;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
      if (n == 2) v_sync = 1;
      if (ovr_at > 0 && n == ovr_at) v_sync = 0;
      if (ovr_at > 0 && n == ovr_at + 2) v_sync = 1;
    end
    v_sync = 1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL %s done_pulses got=%0d exp=1", tag, done_cnt); end
    checks++;
    if (done_cyc - busy_cyc !== lat) begin failures++; $display("FAIL %s done_latency got=%0d exp=%0d", tag, done_cyc - busy_cyc, lat); end
    checks++;
    if (ovr_cnt !== (ovr_at > 0 ? 1 : 0)) begin failures++; $display("FAIL %s overrun_pulses got=%0d exp=%0d", tag, ovr_cnt, ovr_at > 0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b exp=0", tag, busy); end
    checks++;
    if (wq.size() !== eq.size()) begin failures++; $display("FAIL %s write_count got=%0d exp=%0d", tag, wq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== eq[i]) begin failures++; $display("FAIL %s write[%0d] got=%h:%h exp=%h:%h", tag, i, wq[i].a, wq[i].d, eq[i].a, eq[i].d); end
    end
    checks++;
    if (rq0.size() !== e0.size() || rq1.size() !== e1.size()) begin
      failures++; $display("FAIL %s read_count got=%0d/%0d exp=%0d/%0d", tag, rq0.size(), rq1.size(), e0.size(), e1.size());
    end
    for (int j = 0; j < e0.size() && j < rq0.size(); j++) begin
      checks++;
      if (rq0[j] !== e0[j]) begin failures++; $display("FAIL %s ch0_addr[%0d] got=%h exp=%h", tag, j, rq0[j], e0[j]); end
    end
    for (int j = 0; j < e1.size() && j < rq1.size(); j++) begin
      checks++;
      if (rq1[j] !== e1[j]) begin failures++; $display("FAIL %s ch1_addr[%0d] got=%h exp=%h", tag, j, rq1[j], e1[j]); end
    end
    checks++;
    if (ceq.size() !== (ctrl[0] ? CE : 0)) begin failures++; $display("FAIL %s enable_count got=%0d exp=%0d", tag, ceq.size(), ctrl[0] ? CE : 0); end
    for (int i = 0; i < ceq.size() && ctrl[0] && i < CE; i++) begin
      checks++;
      if (ceq[i] !== one << i) begin failures++; $display("FAIL %s enable[%0d] got=%h exp=%h", tag, i, ceq[i], one << i); end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    #3;
    checks++;
    if ({aux_wr, busy, done, ovr, mem_rd, ce, aux_wa, aux_wdata, aux_ra, mem_addr} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%h exp=all zero", aux_wr, busy, done, ovr, mem_rd, ce);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || wq.size() !== 0) begin failures++; $display("FAIL reset_idle busy=%b writes=%0d exp=0/0", busy, wq.size()); end
  endtask

  task automatic test_full;
    run_frame(16'h0007, 11'h7FF, 11'h010, 0, "full");
    checks++;
    if (rq0.size() !== 4 || rq0[0] !== 11'h7FF || rq0[1] !== 11'h000 || rq0[3] !== 11'h002) begin
      failures++; $display("FAIL full_wrap got_size=%0d exp ch0 7ff,000,001,002", rq0.size());
    end
  endtask

  task automatic test_cpu_only;
    run_frame(16'h0001, 11'($urandom), 11'($urandom), 0, "cpu_only");
    checks++;
    if (rq0.size() + rq1.size() !== 0) begin failures++; $display("FAIL cpu_only_reads got=%0d exp=0", rq0.size() + rq1.size()); end
  endtask

  task automatic test_ch1_only;
    for (int i = 18; i < 22; i++) aux_mem[i] = 16'hDEAD;
    run_frame(16'h0004, 11'($urandom), 11'($urandom), 0, "ch1_only");
    for (int i = 18; i < 22; i++) begin
      checks++;
      if (aux_mem[i] !== 16'hDEAD) begin failures++; $display("FAIL ch1_only_untouched[%0d] got=%h exp=dead", i, aux_mem[i]); end
    end
  endtask

  task automatic test_ignored_bits;
    run_frame(16'hFFF8, 11'($urandom), 11'($urandom), 0, "ignored_bits");
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) run_frame(16'($urandom), 11'($urandom), 11'($urandom), 0, $sformatf("random%0d", r));
  endtask

  task automatic test_overrun;
    run_frame(16'h0007, 11'($urandom), 11'($urandom), 17, "overrun");
  endtask

  task automatic test_reset_abort;
    int n0;
    aux_mem[0] = 16'h0007;
    wq.delete();
    done_cnt = 0;
    @(posedge clk); #2 v_sync = 0;
    repeat (8) @(posedge clk);
    #2 v_sync = 1;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({aux_wr, busy, done, ovr, mem_rd, ce, aux_wa, aux_wdata, aux_ra, mem_addr} !== '0) begin
      failures++; $display("FAIL abort_outputs got=%b/%b/%b/%b/%h exp=all zero", aux_wr, busy, done, mem_rd, ce);
    end
    n0 = wq.size();
    checks++;
    if (n0 < 1 || n0 >= CE) begin failures++; $display("FAIL abort_mid_cpu writes_before=%0d exp=1..%0d", n0, CE - 1); end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (wq.size() !== n0 || done_cnt !== 0) begin
      failures++; $display("FAIL abort_quiet writes=%0d done=%0d exp=%0d/0", wq.size(), done_cnt, n0);
    end
    rst_n = 1;
    repeat (3) @(posedge clk);
    run_frame(16'h0007, 11'($urandom), 11'($urandom), 0, "post_reset");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) aux_mem[i] = DW'($urandom);
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = DW'($urandom);
      mem1[i] = DW'($urandom);
    end
    for (int i = 0; i < CE; i++) cpu_regs[i] = '0;
    test_reset();
    test_full();
    test_cpu_only();
    test_ch1_only();
    test_ignored_bits();
    test_random();
    test_overrun();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
